// File: rtl/cart_loader.sv
// Buffers the hps_io download stream into a small FIFO and drains it to SDRAM, one write per ce slot.
// Latency: a pushed word reaches sd_we on the next free ce edge; header/checksum are captured at push time.
// Backpressure: registered ioctl_wait at FIFO_DEPTH-1 entries; words pushed while full are dropped (sticky overflow).
module cart_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 25
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    output logic              sd_we,
    output logic [ADDR_W-2:0] sd_addr,
    output logic [15:0]       sd_din,
    output logic [7:0]        cart_mbc_type,
    output logic [7:0]        cart_rom_size,
    output logic [7:0]        cart_ram_size,
    output logic              hdr_chk_ok,
    output logic              cart_ready,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Word addresses of the header bytes (byte address >> 1).
    localparam logic [ADDR_W-2:0] WA_CHK_FIRST = (ADDR_W-1)'('h09A);
    localparam logic [ADDR_W-2:0] WA_CHK_LAST  = (ADDR_W-1)'('h0A5);
    localparam logic [ADDR_W-2:0] WA_CHK_REF   = (ADDR_W-1)'('h0A6);
    localparam logic [ADDR_W-2:0] WA_MBC       = (ADDR_W-1)'('h0A3);
    localparam logic [ADDR_W-2:0] WA_SIZES     = (ADDR_W-1)'('h0A4);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-2:0] addr;
        logic [15:0]       dat;
    } entry_t;

    state_t            state, state_nxt;
    logic              dl_q;
    logic              dl_rise, dl_fall;
    logic              enter_load, enter_done;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              full, empty;
    logic              wr_in_load, push_ok, pop;
    logic              sd_we_nxt;

    logic [ADDR_W-2:0] wa;
    logic [7:0]        lo, hi;
    logic [7:0]        acc, chk_ref;
    logic              unused_addr_lsb;

    assign wa              = ioctl_addr[ADDR_W-1:1];
    assign lo              = ioctl_dout[7:0];
    assign hi              = ioctl_dout[15:8];
    assign unused_addr_lsb = ioctl_addr[0];

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign wr_in_load = ioctl_wr & (state == LOAD);
    assign push_ok    = wr_in_load & ~full;
    assign pop        = ce & ~sd_we & ~empty;
    // A write stays up for one whole ce period, then the slot after it is idle.
    assign sd_we_nxt  = pop | (sd_we & ~ce);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dl_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            dl_q  <= ioctl_download;
        end
    end

    // DONE is entered on the very edge that retires the last write.
    always_comb begin
        state_nxt  = state;
        enter_load = 1'b0;
        enter_done = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (dl_rise) begin
                    state_nxt  = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (dl_fall) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (count_nxt == '0 && !sd_we_nxt) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{addr: wa, dat: ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
            sd_we      <= 1'b0;
            sd_addr    <= '0;
            sd_din     <= '0;
        end else begin
            count      <= count_nxt;
            ioctl_wait <= (count_nxt >= CNT_W'(FIFO_DEPTH - 1));
            sd_we      <= sd_we_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                sd_addr <= mem[rd_ptr].addr;
                sd_din  <= mem[rd_ptr].dat;
            end
        end
    end

    // Running Game Boy header checksum: x = x - byte - 1 over 0x134..0x14C.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cart_mbc_type <= '0;
            cart_rom_size <= '0;
            cart_ram_size <= '0;
            hdr_chk_ok    <= 1'b0;
            cart_ready    <= 1'b0;
            overflow      <= 1'b0;
            acc           <= '0;
            chk_ref       <= '0;
        end else if (enter_load) begin
            cart_mbc_type <= '0;
            cart_rom_size <= '0;
            cart_ram_size <= '0;
            hdr_chk_ok    <= 1'b0;
            cart_ready    <= 1'b0;
            overflow      <= 1'b0;
            acc           <= '0;
            chk_ref       <= '0;
        end else begin
            if (wr_in_load && full) begin
                overflow <= 1'b1;
            end
            if (push_ok) begin
                if (wa == WA_MBC) begin
                    cart_mbc_type <= hi;
                end
                if (wa == WA_SIZES) begin
                    cart_rom_size <= lo;
                    cart_ram_size <= hi;
                end
                if (wa >= WA_CHK_FIRST && wa <= WA_CHK_LAST) begin
                    acc <= acc - lo - hi - 8'd2;
                end else if (wa == WA_CHK_REF) begin
                    acc     <= acc - lo - 8'd1;
                    chk_ref <= hi;
                end
            end
            if (enter_done) begin
                cart_ready <= 1'b1;
                hdr_chk_ok <= (acc == chk_ref);
            end
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// Scoreboard bench for cart_loader: stimulus queues expected SDRAM writes, a monitor pops and compares on each sd_we pulse.
module tb_cart_loader;

    logic        clk_sys;
    logic        reset_n;
    logic        ce;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        sd_we;
    logic [23:0] sd_addr;
    logic [15:0] sd_din;
    logic [7:0]  cart_mbc_type;
    logic [7:0]  cart_rom_size;
    logic [7:0]  cart_ram_size;
    logic        hdr_chk_ok;
    logic        cart_ready;
    logic        overflow;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] dat;
    } wr_t;

    wr_t  exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [2:0] ce_ph;

    cart_loader #(.FIFO_DEPTH(4), .ADDR_W(25)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ce             (ce),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .sd_we          (sd_we),
        .sd_addr        (sd_addr),
        .sd_din         (sd_din),
        .cart_mbc_type  (cart_mbc_type),
        .cart_rom_size  (cart_rom_size),
        .cart_ram_size  (cart_ram_size),
        .hdr_chk_ok     (hdr_chk_ok),
        .cart_ready     (cart_ready),
        .overflow       (overflow)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // ce is updated 1 time unit after each edge, stimulus at 2, so stimulus always sees the fresh ce.
    initial begin
        ce    = 1'b0;
        ce_ph = 3'd0;
        forever begin
            @(posedge clk_sys);
            #1;
            ce_ph = ce_ph + 3'd1;
            ce    = (ce_ph == 3'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    // Monitor: one pop per sd_we rising edge; pulse width and spacing checked in clocks.
    logic prev_we;
    int   hi_len, lo_len;
    bit   seen_fall;
    wr_t  got;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_we   = 1'b0;
            hi_len    = 0;
            lo_len    = 0;
            seen_fall = 1'b0;
        end else begin
            if (sd_we && !prev_we) begin
                if (seen_fall) check("sd_we_gap_ge8", 64'(lo_len >= 8), 64'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", sd_addr, sd_din);
                end else begin
                    got = exp_q.pop_front();
                    check("sd_addr", 64'(sd_addr), 64'(got.addr));
                    check("sd_din", 64'(sd_din), 64'(got.dat));
                end
                hi_len = 1;
            end else if (sd_we) begin
                hi_len++;
            end else if (prev_we) begin
                check("sd_we_width", 64'(hi_len), 64'd8);
                seen_fall = 1'b1;
                lo_len    = 1;
            end else begin
                lo_len++;
            end
            prev_we = sd_we;
        end
    end

    task automatic write_word(input int w, input logic [15:0] d, input bit expect_it);
        int guard;
        guard = 0;
        while (ioctl_wait && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) fail_now("ioctl_wait_release");
        if (expect_it) exp_q.push_back({w[23:0], d});
        ioctl_addr = {w[23:0], 1'b0};
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        tick();
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    // Returns right after a ce edge: the next ce edge is 8 clocks away.
    task automatic align_ce();
        int guard;
        guard = 0;
        while (!ce && guard < 16) begin
            tick();
            guard++;
        end
        if (guard >= 16) fail_now("ce_align");
        tick();
    endtask

    task automatic finish_download(input string tag);
        int guard;
        ioctl_download = 1'b0;
        guard = 0;
        while (!cart_ready && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) fail_now({tag, "_cart_ready_timeout"});
        check({tag, "_cart_ready"}, 64'(cart_ready), 64'd1);
        check({tag, "_all_words_written"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [7:0] img_byte(input int a, input logic [7:0] chk);
        case (a)
            'h147:   return 8'h03;
            'h148:   return 8'h05;
            'h149:   return 8'h03;
            'h14D:   return chk;
            default: return 8'h00;
        endcase
    endfunction

    task automatic load_image(input logic [7:0] chk, input bit exp_ok, input bit check_clear, input string tag);
        start_download();
        if (check_clear) begin
            check("reraise_cart_ready", 64'(cart_ready), 64'd0);
            check("reraise_mbc", 64'(cart_mbc_type), 64'd0);
            check("reraise_rom", 64'(cart_rom_size), 64'd0);
            check("reraise_ram", 64'(cart_ram_size), 64'd0);
            check("reraise_chk_ok", 64'(hdr_chk_ok), 64'd0);
        end
        for (int w = 0; w < 'hA8; w++) begin
            write_word(w, {img_byte(2 * w + 1, chk), img_byte(2 * w, chk)}, 1'b1);
        end
        finish_download(tag);
        check({tag, "_mbc"}, 64'(cart_mbc_type), 64'h03);
        check({tag, "_rom"}, 64'(cart_rom_size), 64'h05);
        check({tag, "_ram"}, 64'(cart_ram_size), 64'h03);
        check({tag, "_chk_ok"}, 64'(hdr_chk_ok), 64'(exp_ok));
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset_ctrl", {59'd0, ioctl_wait, sd_we, hdr_chk_ok, cart_ready, overflow}, 64'd0);
        check("reset_hdr", {40'd0, cart_mbc_type, cart_rom_size, cart_ram_size}, 64'd0);

        // Paced host: ioctl_wait at 3 entries, then drop download with 3 words queued.
        start_download();
        align_ce();
        exp_q.push_back({24'd0, 16'hA000});
        exp_q.push_back({24'd1, 16'hA001});
        exp_q.push_back({24'd2, 16'hA002});
        exp_q.push_back({24'd3, 16'hA003});
        ioctl_addr = 25'd0; ioctl_dout = 16'hA000; ioctl_wr = 1'b1;
        tick();                                         // E+1: 1 entry
        ioctl_wr = 1'b0;
        check("wait_at_1", 64'(ioctl_wait), 64'd0);
        tick();
        ioctl_addr = 25'd2; ioctl_dout = 16'hA001; ioctl_wr = 1'b1;
        tick();                                         // E+3: 2 entries
        ioctl_wr = 1'b0;
        check("wait_at_2", 64'(ioctl_wait), 64'd0);
        tick();
        ioctl_addr = 25'd4; ioctl_dout = 16'hA002; ioctl_wr = 1'b1;
        tick();                                         // E+5: 3 entries
        ioctl_wr = 1'b0;
        check("wait_at_3", 64'(ioctl_wait), 64'd1);
        tick();
        tick();                                         // E+7
        check("wait_held", 64'(ioctl_wait), 64'd1);
        tick();                                         // E+8: ce pops word 0
        check("wait_after_pop", 64'(ioctl_wait), 64'd0);
        check("first_sd_we", 64'(sd_we), 64'd1);
        ioctl_addr = 25'd6; ioctl_dout = 16'hA003; ioctl_wr = 1'b1;
        tick();                                         // E+9: 3 entries again
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();                                         // E+10: LOAD -> FLUSH
        repeat (53) tick();                             // E+63
        check("flush_not_ready", 64'(cart_ready), 64'd0);
        tick();                                         // E+64: third queued write retires
        check("flush_ready_edge", 64'(cart_ready), 64'd1);
        check("flush_chk_ok_no_hdr", 64'(hdr_chk_ok), 64'd1);
        check("flush_queue_empty", 64'(exp_q.size()), 64'd0);
        check("flush_no_overflow", 64'(overflow), 64'd0);

        load_image(8'hDC, 1'b1, 1'b0, "img_good");
        load_image(8'hDD, 1'b0, 1'b1, "img_bad");

        // Host ignores ioctl_wait: 6 back-to-back words, only 4 fit before the next ce.
        start_download();
        align_ce();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back({24'(8'h40 + i), 16'(16'hB000 + i)});
            ioctl_addr = 25'((8'h40 + i) * 2);
            ioctl_dout = 16'(16'hB000 + i);
            ioctl_wr   = 1'b1;
            tick();
        end
        ioctl_wr = 1'b0;
        check("burst_overflow", 64'(overflow), 64'd1);
        finish_download("burst");
        check("burst_overflow_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset while a write is in flight.
        start_download();
        write_word(16, 16'hC010, 1'b1);
        write_word(17, 16'hC011, 1'b1);
        begin
            int guard;
            guard = 0;
            while (!sd_we && guard < 40) begin
                tick();
                guard++;
            end
            if (guard >= 40) fail_now("rst_wait_sd_we");
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_ctrl", {59'd0, ioctl_wait, sd_we, hdr_chk_ok, cart_ready, overflow}, 64'd0);
        check("async_rst_data", {24'd0, sd_addr, sd_din}, 64'd0);
        check("async_rst_hdr", {40'd0, cart_mbc_type, cart_rom_size, cart_ram_size}, 64'd0);
        exp_q.delete();
        ioctl_download = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        ioctl_addr = 25'd8; ioctl_dout = 16'hDEAD; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        repeat (30) tick();
        check("post_rst_cart_ready", 64'(cart_ready), 64'd0);
        check("post_rst_idle_no_write", 64'(sd_we), 64'd0);
        check("post_rst_wait", 64'(ioctl_wait), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
